// File: rtl/execute_mc_if.sv
// execute_mc_if: bundle between the Decode/Execute register, the hazard
// unit and the Memory stage for the multi-cycle Execute stage.
//   slave  : the Execute stage (consumes Decode controls/operands,
//            produces stall, branch resolution, flags and the E/M register)
//   master : whoever drives Execute (pipeline glue or a testbench)
// Parameters: WIDTH (datapath width), ADDR_W (register-address width).
interface execute_mc_if #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 4
);
    logic              valid_e;
    logic              reg_write_e;
    logic              mem_to_reg_e;
    logic              mem_write_e;
    logic              pc_src_e;
    logic              branch_e;
    logic              alu_src_e;
    logic              flag_write_e;
    logic [1:0]        fwd_a_e;
    logic [1:0]        fwd_b_e;
    logic [WIDTH-1:0]  rd_a_e;
    logic [WIDTH-1:0]  rd_b_e;
    logic [WIDTH-1:0]  ext_e;
    logic [WIDTH-1:0]  result_w;
    logic [WIDTH-1:0]  fwd_m;
    logic [ADDR_W-1:0] wa3_e;
    logic [3:0]        alu_control_e;
    logic [3:0]        cond_e;
    logic              flush_m;

    logic              stall_e;
    logic              branch_taken_e;
    logic [3:0]        flags_o;
    logic [WIDTH-1:0]  alu_result_m;
    logic [WIDTH-1:0]  write_data_m;
    logic [ADDR_W-1:0] wa3_m;
    logic              reg_write_m;
    logic              mem_to_reg_m;
    logic              mem_write_m;
    logic              pc_src_m;

    modport slave (
        input  valid_e, reg_write_e, mem_to_reg_e, mem_write_e, pc_src_e,
               branch_e, alu_src_e, flag_write_e, fwd_a_e, fwd_b_e,
               rd_a_e, rd_b_e, ext_e, result_w, fwd_m, wa3_e,
               alu_control_e, cond_e, flush_m,
        output stall_e, branch_taken_e, flags_o, alu_result_m, write_data_m,
               wa3_m, reg_write_m, mem_to_reg_m, mem_write_m, pc_src_m
    );

    modport master (
        output valid_e, reg_write_e, mem_to_reg_e, mem_write_e, pc_src_e,
               branch_e, alu_src_e, flag_write_e, fwd_a_e, fwd_b_e,
               rd_a_e, rd_b_e, ext_e, result_w, fwd_m, wa3_e,
               alu_control_e, cond_e, flush_m,
        input  stall_e, branch_taken_e, flags_o, alu_result_m, write_data_m,
               wa3_m, reg_write_m, mem_to_reg_m, mem_write_m, pc_src_m
    );
endinterface

// File: rtl/execute_mc.sv
// execute_mc: multi-cycle Execute stage of the pipelined ARM core.
// Forwarding muxes, ALU, NZCV flag register, ARM condition check and the
// Execute/Memory pipeline register with bubble/flush control. With the
// EXEC_MUL_EN macro defined, op 1000 runs an iterative shift-add multiplier
// that stalls the front of the pipe; without it, op 1000 is an undefined op.
// Ports:
//   clk   : clock, all state changes on the rising edge
//   reset : synchronous, active-low
//   bus   : execute_mc_if.slave (Decode inputs, hazard/branch outputs, E/M)
module execute_mc #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 4
) (
    input  logic        clk,
    input  logic        reset,
    execute_mc_if.slave bus
);
    localparam int MSB = WIDTH - 1;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_ORR = 4'b0011;
    localparam logic [3:0] OP_EOR = 4'b0100;
    localparam logic [3:0] OP_MOV = 4'b0101;

    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b_reg;
    logic [WIDTH-1:0] src_b;
    logic [WIDTH:0]   add_full;
    logic [WIDTH:0]   sub_full;
    logic [WIDTH-1:0] result;
    logic             c_next;
    logic             v_next;
    logic [3:0]       flags_next;
    logic [3:0]       flags_q;
    logic             n_q, z_q, c_q, v_q;
    logic             cond_pass;
    logic             cond_ex;
    logic             stall;
    logic             commit;

    logic [WIDTH-1:0]  alu_result_q;
    logic [WIDTH-1:0]  write_data_q;
    logic [ADDR_W-1:0] wa3_q;
    logic              reg_write_q;
    logic              mem_to_reg_q;
    logic              mem_write_q;
    logic              pc_src_q;

    assign {n_q, z_q, c_q, v_q} = flags_q;

    // Forwarding: codes 00 and 11 both take the register file value.
    always_comb begin
        case (bus.fwd_a_e)
            2'b01:   src_a = bus.result_w;
            2'b10:   src_a = bus.fwd_m;
            default: src_a = bus.rd_a_e;
        endcase
        case (bus.fwd_b_e)
            2'b01:   src_b_reg = bus.result_w;
            2'b10:   src_b_reg = bus.fwd_m;
            default: src_b_reg = bus.rd_b_e;
        endcase
    end

    assign src_b = bus.alu_src_e ? bus.ext_e : src_b_reg;

    // Condition check against the stored flags; 1111 never executes.
    always_comb begin
        case (bus.cond_e)
            4'b0000: cond_pass = z_q;
            4'b0001: cond_pass = ~z_q;
            4'b0010: cond_pass = c_q;
            4'b0011: cond_pass = ~c_q;
            4'b0100: cond_pass = n_q;
            4'b0101: cond_pass = ~n_q;
            4'b0110: cond_pass = v_q;
            4'b0111: cond_pass = ~v_q;
            4'b1000: cond_pass = c_q & ~z_q;
            4'b1001: cond_pass = ~c_q | z_q;
            4'b1010: cond_pass = (n_q == v_q);
            4'b1011: cond_pass = (n_q != v_q);
            4'b1100: cond_pass = ~z_q & (n_q == v_q);
            4'b1101: cond_pass = z_q | (n_q != v_q);
            4'b1110: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end

    assign cond_ex = bus.valid_e & cond_pass;

    // SUB is A + ~B + 1 so the carry out means "no borrow".
    assign add_full = {1'b0, src_a} + {1'b0, src_b};
    assign sub_full = {1'b0, src_a} + {1'b0, ~src_b} + {{WIDTH{1'b0}}, 1'b1};

`ifdef EXEC_MUL_EN
    localparam logic [3:0] OP_MUL = 4'b1000;
    localparam int         CNT_W  = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} mul_state_t;

    mul_state_t       state_q, state_d;
    logic [CNT_W-1:0] count_q;
    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [WIDTH-1:0] acc_q;
    logic             mul_start;

    // A MUL that fails its condition never starts and retires as annulled.
    assign mul_start = (state_q == IDLE) && bus.valid_e &&
                       (bus.alu_control_e == OP_MUL) && cond_ex;

    always_ff @(posedge clk) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (mul_start) state_d = RUN;
            RUN:     if (count_q == CNT_W'(WIDTH - 1)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The capture cycle already stalls so the operands stay put upstream.
    always_comb begin
        stall = 1'b0;
        case (state_q)
            IDLE:    stall = mul_start;
            RUN:     stall = 1'b1;
            default: stall = 1'b0;
        endcase
    end

    // Operands are latched at capture, so forwarding changes during RUN
    // cannot disturb the product.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q  <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (mul_start) begin
                        mcand_q  <= src_a;
                        mplier_q <= src_b;
                        acc_q    <= '0;
                        count_q  <= '0;
                    end
                end
                RUN: begin
                    if (mplier_q[0]) acc_q <= acc_q + mcand_q;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    count_q  <= count_q + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end
`else
    assign stall = 1'b0;
`endif

    // Logic, MOV, MUL and undefined ops leave C and V untouched.
    always_comb begin
        result = '0;
        c_next = c_q;
        v_next = v_q;
        case (bus.alu_control_e)
            OP_ADD: begin
                result = add_full[MSB:0];
                c_next = add_full[WIDTH];
                v_next = (src_a[MSB] == src_b[MSB]) && (add_full[MSB] != src_a[MSB]);
            end
            OP_SUB: begin
                result = sub_full[MSB:0];
                c_next = sub_full[WIDTH];
                v_next = (src_a[MSB] != src_b[MSB]) && (sub_full[MSB] != src_a[MSB]);
            end
            OP_AND: result = src_a & src_b;
            OP_ORR: result = src_a | src_b;
            OP_EOR: result = src_a ^ src_b;
            OP_MOV: result = src_b;
`ifdef EXEC_MUL_EN
            OP_MUL: result = acc_q;
`endif
            default: result = '0;
        endcase
    end

    assign flags_next = {result[MSB], (result == '0), c_next, v_next};
    assign commit     = cond_ex & ~stall;

    always_ff @(posedge clk) begin
        if (!reset)                           flags_q <= 4'b0000;
        else if (commit && bus.flag_write_e)  flags_q <= flags_next;
    end

    // Data fields load every cycle; only the control bits are gated.
    // A stall or flush turns the slot into a bubble.
    always_ff @(posedge clk) begin
        if (!reset) begin
            alu_result_q <= '0;
            write_data_q <= '0;
            wa3_q        <= '0;
            reg_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            mem_write_q  <= 1'b0;
            pc_src_q     <= 1'b0;
        end else begin
            alu_result_q <= result;
            write_data_q <= src_b_reg;
            wa3_q        <= bus.wa3_e;
            if (stall || bus.flush_m) begin
                reg_write_q  <= 1'b0;
                mem_to_reg_q <= 1'b0;
                mem_write_q  <= 1'b0;
                pc_src_q     <= 1'b0;
            end else begin
                reg_write_q  <= bus.reg_write_e & cond_ex;
                mem_to_reg_q <= bus.mem_to_reg_e;
                mem_write_q  <= bus.mem_write_e & cond_ex;
                pc_src_q     <= bus.pc_src_e & cond_ex;
            end
        end
    end

    assign bus.stall_e        = stall;
    assign bus.branch_taken_e = bus.branch_e & commit;
    assign bus.flags_o        = flags_q;
    assign bus.alu_result_m   = alu_result_q;
    assign bus.write_data_m   = write_data_q;
    assign bus.wa3_m          = wa3_q;
    assign bus.reg_write_m    = reg_write_q;
    assign bus.mem_to_reg_m   = mem_to_reg_q;
    assign bus.mem_write_m    = mem_write_q;
    assign bus.pc_src_m       = pc_src_q;
endmodule

// File: tb/tb_execute_mc.sv
// tb_execute_mc: self-checking bench for execute_mc (WIDTH=32, ADDR_W=4).
// A table of vectors carries inputs and hand-derived expected E/M contents;
// expected records are queued when a vector is driven and popped when the
// E/M register is sampled. Hand sequences cover reset, the multiplier
// (EXEC_MUL_EN) or the undefined op 1000 (default build).
module tb_execute_mc;
    localparam int WIDTH  = 32;
    localparam int ADDR_W = 4;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    execute_mc_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

    execute_mc #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        logic        valid;
        logic [3:0]  op;
        logic [3:0]  cond;
        logic [31:0] a, b, ext;
        logic        src;
        logic [1:0]  fa, fb;
        logic [31:0] rwv, fmv;
        logic        fw, rw, mw, m2r, br, fl;
        logic [3:0]  wa3;
        logic [31:0] e_res, e_wd;
        logic [3:0]  e_flags;
        logic        e_rw, e_mw, e_m2r, e_pc, e_bt;
    } vec_t;

    typedef struct {
        logic [31:0] res, wd;
        logic [3:0]  wa3, flags;
        logic        rw, mw, m2r, pc, chk_data;
    } exp_t;

    exp_t expQ[$];
    vec_t vecs[20];
    int   nApplied = 0;
    int   nMiss    = 0;

    // Argument order: valid op cond a b ext src fa fb result_w fwd_m
    // fw rw mw m2r br flush wa3 | exp: res wdata flags rw mw m2r pc bt
    function automatic vec_t mk(
        input logic valid, input logic [3:0] op, input logic [3:0] cond,
        input logic [31:0] a, input logic [31:0] b, input logic [31:0] ext,
        input logic src, input logic [1:0] fa, input logic [1:0] fb,
        input logic [31:0] rwv, input logic [31:0] fmv,
        input logic fw, input logic rw, input logic mw, input logic m2r,
        input logic br, input logic fl, input logic [3:0] wa3,
        input logic [31:0] e_res, input logic [31:0] e_wd, input logic [3:0] e_flags,
        input logic e_rw, input logic e_mw, input logic e_m2r, input logic e_pc,
        input logic e_bt);
        vec_t v;
        v.valid = valid; v.op = op; v.cond = cond; v.a = a; v.b = b; v.ext = ext;
        v.src = src; v.fa = fa; v.fb = fb; v.rwv = rwv; v.fmv = fmv;
        v.fw = fw; v.rw = rw; v.mw = mw; v.m2r = m2r; v.br = br; v.fl = fl;
        v.wa3 = wa3; v.e_res = e_res; v.e_wd = e_wd; v.e_flags = e_flags;
        v.e_rw = e_rw; v.e_mw = e_mw; v.e_m2r = e_m2r; v.e_pc = e_pc; v.e_bt = e_bt;
        return v;
    endfunction

    task automatic compareVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        nApplied++;
        if (act !== exp) begin
            nMiss++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic driveIdle();
        bus.valid_e = 1'b0; bus.reg_write_e = 1'b0; bus.mem_to_reg_e = 1'b0;
        bus.mem_write_e = 1'b0; bus.pc_src_e = 1'b0; bus.branch_e = 1'b0;
        bus.alu_src_e = 1'b0; bus.flag_write_e = 1'b0; bus.fwd_a_e = 2'b00;
        bus.fwd_b_e = 2'b00; bus.rd_a_e = '0; bus.rd_b_e = '0; bus.ext_e = '0;
        bus.result_w = '0; bus.fwd_m = '0; bus.wa3_e = '0;
        bus.alu_control_e = 4'b0000; bus.cond_e = 4'b1110; bus.flush_m = 1'b0;
    endtask

    // Drive one instruction, check the combinational outputs and queue the
    // E/M contents expected after the next rising edge.
    task automatic applyStimulus(input vec_t v, input logic expStall, input string tag);
        exp_t e;
        bus.valid_e = v.valid; bus.alu_control_e = v.op; bus.cond_e = v.cond;
        bus.rd_a_e = v.a; bus.rd_b_e = v.b; bus.ext_e = v.ext; bus.alu_src_e = v.src;
        bus.fwd_a_e = v.fa; bus.fwd_b_e = v.fb; bus.result_w = v.rwv; bus.fwd_m = v.fmv;
        bus.flag_write_e = v.fw; bus.reg_write_e = v.rw; bus.mem_write_e = v.mw;
        bus.mem_to_reg_e = v.m2r; bus.branch_e = v.br; bus.pc_src_e = v.br;
        bus.flush_m = v.fl; bus.wa3_e = v.wa3;
        #1;
        compareVal({tag, " stall_e"}, 32'(bus.stall_e), 32'(expStall));
        compareVal({tag, " branch_taken_e"}, 32'(bus.branch_taken_e), 32'(v.e_bt));
        e.res = v.e_res; e.wd = v.e_wd; e.wa3 = v.wa3; e.flags = v.e_flags;
        e.rw = v.e_rw; e.mw = v.e_mw; e.m2r = v.e_m2r; e.pc = v.e_pc;
        e.chk_data = ~v.fl;
        expQ.push_back(e);
    endtask

    task automatic checkOutput(input string tag);
        exp_t e;
        if (expQ.size() == 0) begin
            compareVal({tag, " scoreboard empty"}, 32'd1, 32'd0);
        end else begin
            e = expQ.pop_front();
            if (e.chk_data) begin
                compareVal({tag, " alu_result_m"}, bus.alu_result_m, e.res);
                compareVal({tag, " write_data_m"}, bus.write_data_m, e.wd);
                compareVal({tag, " wa3_m"}, 32'(bus.wa3_m), 32'(e.wa3));
            end
            compareVal({tag, " flags_o"}, 32'(bus.flags_o), 32'(e.flags));
            compareVal({tag, " reg_write_m"}, 32'(bus.reg_write_m), 32'(e.rw));
            compareVal({tag, " mem_write_m"}, 32'(bus.mem_write_m), 32'(e.mw));
            compareVal({tag, " mem_to_reg_m"}, 32'(bus.mem_to_reg_m), 32'(e.m2r));
            compareVal({tag, " pc_src_m"}, 32'(bus.pc_src_m), 32'(e.pc));
        end
    endtask

    task automatic checkAllZero(input string tag);
        compareVal({tag, " stall_e"}, 32'(bus.stall_e), 32'd0);
        compareVal({tag, " branch_taken_e"}, 32'(bus.branch_taken_e), 32'd0);
        compareVal({tag, " flags_o"}, 32'(bus.flags_o), 32'd0);
        compareVal({tag, " alu_result_m"}, bus.alu_result_m, 32'd0);
        compareVal({tag, " write_data_m"}, bus.write_data_m, 32'd0);
        compareVal({tag, " wa3_m"}, 32'(bus.wa3_m), 32'd0);
        compareVal({tag, " ctrl_m"}, 32'({bus.reg_write_m, bus.mem_to_reg_m, bus.mem_write_m, bus.pc_src_m}), 32'd0);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        vec_t v;
        int   stallCycles;

        vecs[0]  = mk(1, 4'h0, 4'hE, 32'h7FFFFFFF, 32'h1, 0, 0, 2'b00, 2'b00, 0, 0, 1, 1, 0, 0, 0, 0, 4'd3, 32'h80000000, 32'h1, 4'b1001, 1, 0, 0, 0, 0);
        vecs[1]  = mk(1, 4'h1, 4'hE, 32'h111, 32'h22, 32'h5, 1, 2'b10, 2'b00, 0, 32'h5, 1, 1, 0, 0, 0, 0, 4'd4, 32'h0, 32'h22, 4'b0110, 1, 0, 0, 0, 0);
        vecs[2]  = mk(1, 4'h0, 4'h0, 32'h100, 32'h0, 32'h8, 1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 1, 0, 4'd0, 32'h108, 32'h0, 4'b0110, 0, 0, 0, 1, 1);
        vecs[3]  = mk(1, 4'h0, 4'h1, 32'h1, 32'h2, 0, 0, 2'b00, 2'b00, 0, 0, 1, 1, 1, 0, 0, 0, 4'd2, 32'h3, 32'h2, 4'b0110, 0, 0, 0, 0, 0);
        vecs[4]  = mk(1, 4'h3, 4'hE, 32'hF0, 32'h0F, 0, 0, 2'b00, 2'b00, 0, 0, 0, 1, 1, 1, 0, 1, 4'd1, 32'h0, 32'h0, 4'b0110, 0, 0, 0, 0, 0);
        vecs[5]  = mk(1, 4'h2, 4'hE, 32'hFF00FF00, 32'h0, 0, 0, 2'b00, 2'b01, 32'h0F0F0F0F, 0, 1, 1, 0, 1, 0, 0, 4'd5, 32'h0F000F00, 32'h0F0F0F0F, 4'b0010, 1, 0, 1, 0, 0);
        vecs[6]  = mk(1, 4'h4, 4'hE, 32'hA5A5A5A5, 32'hA5A5A5A5, 0, 0, 2'b00, 2'b00, 0, 0, 1, 1, 0, 0, 0, 0, 4'd6, 32'h0, 32'hA5A5A5A5, 4'b0110, 1, 0, 0, 0, 0);
        vecs[7]  = mk(1, 4'h1, 4'hE, 32'h80000000, 32'h1, 0, 0, 2'b00, 2'b00, 0, 0, 1, 1, 0, 0, 0, 0, 4'd7, 32'h7FFFFFFF, 32'h1, 4'b0011, 1, 0, 0, 0, 0);
        vecs[8]  = mk(1, 4'h5, 4'hE, 32'h12345678, 32'h0, 0, 0, 2'b11, 2'b10, 0, 32'h80000001, 1, 1, 0, 0, 0, 0, 4'd8, 32'h80000001, 32'h80000001, 4'b1011, 1, 0, 0, 0, 0);
        vecs[9]  = mk(1, 4'h0, 4'hA, 32'hFFFFFFFF, 32'h1, 0, 0, 2'b00, 2'b00, 0, 0, 1, 1, 0, 0, 0, 0, 4'd9, 32'h0, 32'h1, 4'b0110, 1, 0, 0, 0, 0);
        vecs[10] = mk(1, 4'h0, 4'hB, 32'h1, 32'h1, 0, 0, 2'b00, 2'b00, 0, 0, 1, 1, 1, 0, 0, 0, 4'd10, 32'h2, 32'h1, 4'b0110, 0, 0, 0, 0, 0);
        vecs[11] = mk(1, 4'h0, 4'hF, 32'h1, 32'h1, 0, 0, 2'b00, 2'b00, 0, 0, 1, 1, 0, 0, 1, 0, 4'd11, 32'h2, 32'h1, 4'b0110, 0, 0, 0, 0, 0);
        vecs[12] = mk(0, 4'h3, 4'hE, 32'hF0, 32'h0F, 0, 0, 2'b00, 2'b00, 0, 0, 1, 1, 1, 0, 0, 0, 4'd12, 32'hFF, 32'h0F, 4'b0110, 0, 0, 0, 0, 0);
        vecs[13] = mk(1, 4'h3, 4'hE, 32'h80000000, 32'h0, 0, 0, 2'b00, 2'b00, 0, 0, 1, 1, 0, 0, 0, 0, 4'd13, 32'h80000000, 32'h0, 4'b1010, 1, 0, 0, 0, 0);
        vecs[14] = mk(1, 4'h6, 4'hE, 32'h5, 32'h6, 0, 0, 2'b00, 2'b00, 0, 0, 1, 1, 0, 0, 0, 0, 4'd14, 32'h0, 32'h6, 4'b0110, 1, 0, 0, 0, 0);
        vecs[15] = mk(1, 4'h0, 4'h8, 32'h2, 32'h3, 0, 0, 2'b00, 2'b00, 0, 0, 1, 1, 0, 0, 0, 0, 4'd15, 32'h5, 32'h3, 4'b0110, 0, 0, 0, 0, 0);
        vecs[16] = mk(1, 4'h0, 4'h2, 32'h2, 32'h3, 0, 0, 2'b00, 2'b00, 0, 0, 0, 1, 1, 0, 0, 0, 4'd1, 32'h5, 32'h3, 4'b0110, 1, 1, 0, 0, 0);
        vecs[17] = mk(1, 4'h0, 4'h9, 32'h4, 32'h9, 32'h4, 1, 2'b00, 2'b00, 0, 0, 1, 1, 0, 0, 0, 0, 4'd2, 32'h8, 32'h9, 4'b0000, 1, 0, 0, 0, 0);
        vecs[18] = mk(1, 4'h0, 4'h3, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 2'b00, 2'b00, 0, 0, 1, 1, 0, 0, 0, 0, 4'd3, 32'hFFFFFFFE, 32'hFFFFFFFF, 4'b1010, 1, 0, 0, 0, 0);
        vecs[19] = mk(1, 4'h1, 4'h4, 32'h5, 32'h7, 0, 0, 2'b00, 2'b00, 0, 0, 1, 1, 0, 0, 0, 0, 4'd4, 32'hFFFFFFFE, 32'h7, 4'b1000, 1, 0, 0, 0, 0);

        driveIdle();
        reset = 1'b0;
        step();
        step();
        checkAllZero("reset");
        reset = 1'b1;

        for (int i = 0; i < 20; i++) begin
            applyStimulus(vecs[i], 1'b0, $sformatf("vec%0d", i));
            step();
            checkOutput($sformatf("vec%0d", i));
        end

        // Give C and V known non-zero values and set Z before the op 1000 check.
        applyStimulus(mk(1, 4'h1, 4'hE, 32'h80000000, 32'h1, 0, 0, 2'b00, 2'b00, 0, 0, 1, 1, 0, 0, 0, 0, 4'd7, 32'h7FFFFFFF, 32'h1, 4'b0011, 1, 0, 0, 0, 0), 1'b0, "preSub");
        step();
        checkOutput("preSub");
        applyStimulus(mk(1, 4'h3, 4'hE, 32'h0, 32'h0, 0, 0, 2'b00, 2'b00, 0, 0, 1, 1, 0, 0, 0, 0, 4'd6, 32'h0, 32'h0, 4'b0111, 1, 0, 0, 0, 0), 1'b0, "preOrr");
        step();
        checkOutput("preOrr");

`ifdef EXEC_MUL_EN
        // 0xFFFF x 3 with A forwarded from result_w, which toggles during RUN.
        v = mk(1, 4'h8, 4'hE, 32'h0, 32'h3, 0, 0, 2'b01, 2'b00, 32'hFFFF, 0, 1, 1, 0, 0, 0, 0, 4'd10, 32'h0002FFFD, 32'h3, 4'b0011, 1, 0, 0, 0, 0);
        applyStimulus(v, 1'b1, "mul");
        stallCycles = 0;
        while (bus.stall_e === 1'b1 && stallCycles < 200) begin
            step();
            stallCycles++;
            compareVal("mul bubble ctrl_m", 32'({bus.reg_write_m, bus.mem_write_m, bus.pc_src_m}), 32'd0);
            bus.result_w = $urandom;
            #1;
        end
        compareVal("mul stall cycles", 32'(stallCycles), 32'd33);
        step();
        checkOutput("mul");
        driveIdle();

        // Restart the multiply and reset it in RUN cycle 10.
        applyStimulus(v, 1'b1, "mulRst");
        expQ.delete();
        for (int i = 0; i < 10; i++) begin
            step();
            bus.result_w = $urandom;
        end
        compareVal("mulRst in RUN stall_e", 32'(bus.stall_e), 32'd1);
        reset = 1'b0;
        bus.valid_e = 1'b0;
        step();
        checkAllZero("mulRst after reset");
        reset = 1'b1;
        step();
        compareVal("mulRst idle stall_e", 32'(bus.stall_e), 32'd0);
        compareVal("mulRst no commit ctrl_m", 32'({bus.reg_write_m, bus.mem_write_m, bus.pc_src_m}), 32'd0);
        compareVal("mulRst no commit flags_o", 32'(bus.flags_o), 32'd0);
`else
        // Without the multiplier, op 1000 is undefined: single cycle, result 0.
        v = mk(1, 4'h8, 4'hE, 32'hFFFF, 32'h3, 0, 0, 2'b00, 2'b00, 0, 0, 1, 1, 0, 0, 0, 0, 4'd10, 32'h0, 32'h3, 4'b0111, 1, 0, 0, 0, 0);
        applyStimulus(mk(1, 4'h1, 4'hE, 32'h80000000, 32'h1, 0, 0, 2'b00, 2'b00, 0, 0, 1, 1, 0, 0, 0, 0, 4'd7, 32'h7FFFFFFF, 32'h1, 4'b0011, 1, 0, 0, 0, 0), 1'b0, "preUndef");
        step();
        checkOutput("preUndef");
        applyStimulus(v, 1'b0, "op1000");
        step();
        checkOutput("op1000");
        compareVal("op1000 stall_e after", 32'(bus.stall_e), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nApplied, nMiss);
        $finish;
    end
endmodule

// File: doc/execute_mc.md
# execute_mc

Parametrised, multi-cycle Execute stage for the pipelined ARM core. It adds to the single-cycle stage a WIDTH-generic datapath, an iterative shift-add multiplier with a stall handshake to the hazard unit, and an Execute/Memory register with bubble and flush control. It sits between the Decode/Execute register and the Memory stage. It owns the NZCV flag register and the condition check.

## Interface
Parameters:
- WIDTH, 32, datapath width; even, ≥ 8.
- ADDR_W, 4, register-address width.

Ports:
- Clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low; 0 at a rising edge resets.
- valid_e  in  1  an instruction occupies Execute.
- reg_write_e, mem_to_reg_e, mem_write_e, pc_src_e, branch_e, alu_src_e, flag_write_e  in  1 each  Decode controls.
- fwd_a_e, fwd_b_e  in  2  forwarding selects: 00 register, 01 result_w, 10 fwd_m, 11 register.
- rd_a_e, rd_b_e, ext_e  in  WIDTH  register operands and extended immediate.
- result_w, fwd_m  in  WIDTH  Writeback result and Memory-stage ALU result.
- wa3_e  in  ADDR_W  destination register.
- alu_control_e, cond_e  in  4  operation and ARM condition field.
- flush_m  in  1  load a bubble into E/M.
- stall_e  out  1  Execute busy; hazard unit holds F/D/E.
- branch_taken_e  out  1  branch resolved taken this cycle.
- flags_o  out  4  stored NZCV (N = bit 3).
- alu_result_m, write_data_m  out  WIDTH  E/M registered result and store data.
- wa3_m  out  ADDR_W; reg_write_m, mem_to_reg_m, mem_write_m, pc_src_m  out  1 each  E/M registered controls.

## Operation
- Operand A is the fwd_a_e mux output. Operand B is the fwd_b_e mux output, or ext_e when alu_src_e is set. Store data is the fwd_b_e mux output.
- alu_control_e: 0000 ADD, 0001 SUB (A−B), 0010 AND, 0011 ORR, 0100 EOR, 0101 MOV (B), 1000 MUL (low WIDTH bits of A×B). All other codes give result 0.
- Flags:
  - ADD/SUB: N = msb, Z = result==0, C = carry out (SUB: no borrow), V = signed overflow.
  - Logic, MOV and MUL: update N and Z; C and V keep their stored values.
- Condition check (cond_ex) evaluates cond_e against the stored flags, using ARM EQ..AL codes 0000–1110. Code 1111 is never-execute. valid_e=0 forces cond_ex=0.
- Commit happens when cond_ex=1 and stall_e=0:
  - Flags load when flag_write_e is also set.
  - E/M captures reg_write_e, pc_src_e and mem_write_e gated by cond_ex. mem_to_reg_e, result, store data and wa3_e are captured ungated.
- branch_taken_e = branch_e & cond_ex & ~stall_e.
- Bubble: while stall_e=1 or flush_m=1, E/M control bits load 0; data fields are don't-care. If both happen together, flush_m wins with the same bubble.
- MUL FSM, states IDLE, RUN, DONE:
  - IDLE: if valid_e, op=MUL and cond_ex, capture A and B into internal registers, clear the accumulator, set count=0, assert stall_e, go to RUN.
  - RUN: each cycle, if the multiplier lsb is 1, add the multiplicand to the accumulator. Then shift the multiplicand left and the multiplier right, and increment count. Leave when count==WIDTH−1, going to DONE. stall_e=1 throughout.
  - DONE: stall_e=0; the result is the accumulator. E/M and flags commit normally; go to IDLE.
  - A MUL failing cond_ex never leaves IDLE and commits as an ordinary annulled instruction.
- Operands are latched at capture, so later changes on result_w or fwd_m do not affect the product.

## Timing
- Non-MUL ops: combinational result; E/M outputs valid one cycle after the instruction is in Execute.
- MUL occupies Execute for WIDTH+2 cycles: stall_e is high for WIDTH+1 cycles (capture plus WIDTH RUN cycles), then low in DONE. E/M holds the product the cycle after DONE.
- stall_e is combinational from state and inputs (high in the IDLE capture cycle); upstream stages must hold inputs stable while it is high.
- Reset values: E/M outputs all 0, flags_o = 0000, FSM in IDLE, stall_e = 0, branch_taken_e = 0.
- Reset during RUN: FSM returns to IDLE, the product is discarded, and nothing commits.

## Configuration
- EXEC_MUL_EN defined: multiplier FSM and op 1000 are present as specified.
- EXEC_MUL_EN undefined: no FSM is generated and stall_e is tied to 0. Op 1000 behaves as an undefined op: result 0, N=0, Z=1, single cycle.

## Test plan
- ADD with WIDTH=32, A=0x7FFFFFFF, B=1, flag_write_e=1, cond AL -> alu_result_m=0x80000000 next cycle; flags_o=1001 after commit.
- SUB, fwd_a_e=10, fwd_m=5, ext_e=5, alu_src_e=1, then BEQ in the next cycle -> Z set; branch_taken_e=1 with pc_src_m=1 on the BEQ.
- MUL 0xFFFF×0x0003, WIDTH=32 -> stall_e high 33 cycles, bubbles in E/M, alu_result_m=0x0002FFFD; C and V unchanged.
- MUL with result_w toggling during RUN, then reset=0 in RUN cycle 10 -> product unaffected by toggling; after reset, state IDLE, all outputs 0, no commit.
- cond_e=NE with Z=1, reg_write_e=1, mem_write_e=1 -> reg_write_m=0, mem_write_m=0, flags unchanged; flush_m=1 on the next cycle -> all E/M controls 0.
- EXEC_MUL_EN undefined, op 1000 -> single cycle, stall_e=0, alu_result_m=0.
